// File: rtl/vga_scan.sv
// vga_scan: VGA timing generator with framebuffer scan-out.
//   The screen is a 16x16 grid of cells. Each cell byte is an RGB332 colour read
//   from an external 256x8 RAM. The RAM read is combinational.
//   All pixel state advances once per PIX_DIV clocks, on the pixel tick.
//   Colour and sync are registered together, so both lag the counters by one tick.
// Ports:
//   clk         in   system clock
//   nrst        in   asynchronous reset, active low
//   rd_addr     out  RAM read address {cell_row, cell_col}
//   rd_data     in   RAM read data, RGB332 {r[2:0], g[2:0], b[1:0]}
//   hsync       out  horizontal sync, active low, registered
//   vsync       out  vertical sync, active low, registered
//   red/green/blue out colour levels, zero while blanked, registered
//   frame_start out  one-clk pulse on the tick where hcnt=0 and vcnt=0
module vga_scan #(
    parameter int PIX_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CELL_W   = 40,
    parameter int CELL_H   = 30
) (
    input  logic       clk,
    input  logic       nrst,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] red,
    output logic [2:0] green,
    output logic [1:0] blue,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW  = $clog2(H_TOTAL);
    localparam int VW  = $clog2(V_TOTAL);
    localparam int DW  = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int CXW = (CELL_W > 1) ? $clog2(CELL_W) : 1;
    localparam int CYW = (CELL_H > 1) ? $clog2(CELL_H) : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
    localparam logic [CXW-1:0] CX_LAST = CXW'(CELL_W - 1);
    localparam logic [CYW-1:0] CY_LAST = CYW'(CELL_H - 1);

    logic [DW-1:0]  div_q, div_d;
    logic [HW-1:0]  hcnt_q, hcnt_d;
    logic [VW-1:0]  vcnt_q, vcnt_d;
    logic [CXW-1:0] cx_q, cx_d;
    logic [CYW-1:0] cy_q, cy_d;
    logic [3:0]     col_q, col_d;
    logic [3:0]     row_q, row_d;
    logic           hs_q, hs_d;
    logic           vs_q, vs_d;
    logic [7:0]     rgb_q, rgb_d;
    logic           tick;
    logic           active;

    assign tick = (div_q == DIV_LAST);

    // Counter and cell-index next state. Cell indices step by sub-counters
    // instead of dividing hcnt/vcnt, and saturate at 15 once the active area
    // ends so the address never leaves the 16x16 grid.
    always_comb begin
        div_d  = tick ? '0 : div_q + DW'(1);
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        cx_d   = cx_q;
        cy_d   = cy_q;
        col_d  = col_q;
        row_d  = row_q;
        if (tick) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                cx_d   = '0;
                col_d  = '0;
                if (vcnt_q == V_LAST) begin
                    vcnt_d = '0;
                    cy_d   = '0;
                    row_d  = '0;
                end else begin
                    vcnt_d = vcnt_q + VW'(1);
                    if (vcnt_q < V_ACT) begin
                        if (cy_q == CY_LAST) begin
                            cy_d = '0;
                            if (row_q != 4'd15) row_d = row_q + 4'd1;
                        end else begin
                            cy_d = cy_q + CYW'(1);
                        end
                    end
                end
            end else begin
                hcnt_d = hcnt_q + HW'(1);
                if (hcnt_q < H_ACT) begin
                    if (cx_q == CX_LAST) begin
                        cx_d = '0;
                        if (col_q != 4'd15) col_d = col_q + 4'd1;
                    end else begin
                        cx_d = cx_q + CXW'(1);
                    end
                end
            end
        end
    end

    // Output stage inputs, all derived from the current (pre-advance) counters.
    always_comb begin
        active = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
        hs_d   = !((hcnt_q >= HS_START) && (hcnt_q < HS_END));
        vs_d   = !((vcnt_q >= VS_START) && (vcnt_q < VS_END));
        rgb_d  = active ? rd_data : 8'h00;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            div_q  <= '0;
            hcnt_q <= '0;
            vcnt_q <= '0;
            cx_q   <= '0;
            cy_q   <= '0;
            col_q  <= '0;
            row_q  <= '0;
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
            rgb_q  <= 8'h00;
        end else begin
            div_q  <= div_d;
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            cx_q   <= cx_d;
            cy_q   <= cy_d;
            col_q  <= col_d;
            row_q  <= row_d;
            if (tick) begin
                hs_q  <= hs_d;
                vs_q  <= vs_d;
                rgb_q <= rgb_d;
            end
        end
    end

    assign rd_addr     = {row_q, col_q};
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign red         = rgb_q[7:5];
    assign green       = rgb_q[4:2];
    assign blue        = rgb_q[1:0];
    // Decoded from registers only; div_q is 0 in reset so this stays low there.
    assign frame_start = tick && (hcnt_q == '0) && (vcnt_q == '0);

endmodule
